// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The master side (stages/bench) drives requests; the slave side (controller) drives freezes.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int WAIT_W = 4,
  parameter int PC_W   = 16
);
  logic [NSTAGE-1:0] stall_req;
  logic              wait_start;
  logic [WAIT_W-1:0] wait_len;
  logic              flush_req;
  logic [PC_W-1:0]   flush_target;
  logic              clr_cnt;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              busy;
  logic [15:0]       stall_cycles;

  modport master (
    output stall_req, wait_start, wait_len, flush_req, flush_target, clr_cnt,
    input  stall, flush, new_pc, busy, stall_cycles
  );

  modport slave (
    input  stall_req, wait_start, wait_len, flush_req, flush_target, clr_cnt,
    output stall, flush, new_pc, busy, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall thermometer from per-stage requests, multi-cycle
// memory waits frozen through MEM_STAGE, registered flush/redirect, and a stall counter.
module pipe_ctrl #(
  parameter int NSTAGE    = 6,
  parameter int MEM_STAGE = 3,
  parameter int WAIT_W    = 4,
  parameter int PC_W      = 16
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] CNT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] CNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic              flush_q, flush_d;
  logic [PC_W-1:0]   new_pc_q, new_pc_d;
  logic              busy_q, busy_d;
  logic [15:0]       scnt_q, scnt_d;
  logic              wait_act_s;
  logic [NSTAGE-1:0] eff_s;
  logic [NSTAGE-1:0] therm_s;
  logic [NSTAGE-1:0] stall_s;

  // Next-state: wait sequencing, flush arbitration and target capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    wait_act_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A flush in the same cycle drops the wait entirely
        if (bus.flush_req) begin
          tgt_d   = bus.flush_target;
          state_d = ST_FLUSH;
        end else if (bus.wait_start && (bus.wait_len != CNT_ZERO)) begin
          wait_act_s = 1'b1;
          if (bus.wait_len != CNT_ONE) begin
            cnt_d   = bus.wait_len - CNT_ONE;
            state_d = ST_WAIT;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_WAIT: begin
        wait_act_s = 1'b1;
        if (bus.flush_req) begin
          pend_d = 1'b1;
          tgt_d  = bus.flush_target;
        end else begin
          pend_d = pend_q;
        end
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          pend_d  = 1'b0;
          state_d = (pend_q || bus.flush_req) ? ST_FLUSH : ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_req) begin
          tgt_d   = bus.flush_target;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
        pend_d  = 1'b0;
      end
    endcase

    flush_d  = (state_d == ST_FLUSH);
    busy_d   = (state_d == ST_WAIT) || (state_d == ST_FLUSH);
    new_pc_d = flush_d ? tgt_d : new_pc_q;
  end

  // Stall vector: freeze every stage at or below the highest requesting stage
  always_comb begin
    eff_s = bus.stall_req;
    if (wait_act_s) begin
      eff_s[MEM_STAGE] = 1'b1;
    end else begin
      eff_s[MEM_STAGE] = bus.stall_req[MEM_STAGE];
    end
    therm_s = {NSTAGE{1'b0}};
    for (int i = 0; i < NSTAGE; i++) begin
      therm_s[i] = |(eff_s >> i);
    end
    if ((state_q == ST_FLUSH) || !rst) begin
      stall_s = {NSTAGE{1'b0}};
    end else begin
      stall_s = therm_s;
    end
  end

  // Saturating stall-cycle counter; clear has priority over counting
  always_comb begin
    if (bus.clr_cnt) begin
      scnt_d = 16'h0000;
    end else if ((stall_s != {NSTAGE{1'b0}}) && (scnt_q != 16'hFFFF)) begin
      scnt_d = scnt_q + 16'h0001;
    end else begin
      scnt_d = scnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= CNT_ZERO;
      pend_q   <= 1'b0;
      tgt_q    <= {PC_W{1'b0}};
      flush_q  <= 1'b0;
      new_pc_q <= {PC_W{1'b0}};
      busy_q   <= 1'b0;
      scnt_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      busy_q   <= busy_d;
      scnt_q   <= scnt_d;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.flush        = flush_q;
  assign bus.new_pc       = new_pc_q;
  assign bus.busy         = busy_q;
  assign bus.stall_cycles = scnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change on the falling edge, outputs are
// checked 1ns later (combinational stall) or after the rising edge (registered).
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_ctrl_if #(.NSTAGE(6), .WAIT_W(4), .PC_W(16)) bus ();

  pipe_ctrl #(.NSTAGE(6), .MEM_STAGE(3), .WAIT_W(4), .PC_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.stall_req    = 6'b000000;
    bus.wait_start   = 1'b0;
    bus.wait_len     = 4'd0;
    bus.flush_req    = 1'b0;
    bus.flush_target = 16'h0000;
    bus.clr_cnt      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #3;
    checks++; if (bus.stall !== 6'b000000) begin failures++; $display("FAIL rst_stall got=%b exp=000000", bus.stall); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", bus.flush); end
    checks++; if (bus.new_pc !== 16'h0000) begin failures++; $display("FAIL rst_new_pc got=%h exp=0000", bus.new_pc); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.stall_cycles !== 16'h0000) begin failures++; $display("FAIL rst_cnt got=%h exp=0000", bus.stall_cycles); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stall_map();
    logic [5:0] req_v [4];
    logic [5:0] exp_v [4];
    req_v = '{6'b000100, 6'b010100, 6'b000000, 6'b100000};
    exp_v = '{6'b000111, 6'b011111, 6'b000000, 6'b111111};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.stall_req = req_v[i];
      #1;
      checks++; if (bus.stall !== exp_v[i]) begin failures++; $display("FAIL stall_map[%0d] got=%b exp=%b", i, bus.stall, exp_v[i]); end
    end
    @(negedge clk);
    bus.stall_req = 6'b000000;
    #1;
    checks++; if (bus.stall_cycles !== 16'd3) begin failures++; $display("FAIL map_cnt got=%0d exp=3", bus.stall_cycles); end
  endtask

  task automatic test_wait();
    logic [5:0] exp_s [4];
    logic       exp_b [4];
    exp_s = '{6'b001111, 6'b001111, 6'b001111, 6'b000000};
    exp_b = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      // A second start with a longer length in WAIT must not extend the wait
      bus.wait_start = (i < 2);
      bus.wait_len   = (i == 0) ? 4'd3 : 4'd7;
      #1;
      checks++; if (bus.stall !== exp_s[i]) begin failures++; $display("FAIL wait3_stall[%0d] got=%b exp=%b", i, bus.stall, exp_s[i]); end
      checks++; if (bus.busy !== exp_b[i]) begin failures++; $display("FAIL wait3_busy[%0d] got=%b exp=%b", i, bus.busy, exp_b[i]); end
    end
    @(negedge clk);
    bus.wait_start = 1'b1;
    bus.wait_len   = 4'd1;
    #1;
    checks++; if (bus.stall !== 6'b001111) begin failures++; $display("FAIL wait1_stall got=%b exp=001111", bus.stall); end
    @(negedge clk);
    bus.wait_len = 4'd0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wait1_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.stall !== 6'b000000) begin failures++; $display("FAIL wait0_stall got=%b exp=000000", bus.stall); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wait0_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.flush_req    = 1'b1;
    bus.flush_target = 16'h1234;
    bus.wait_start   = 1'b1;
    bus.wait_len     = 4'd3;
    #1;
    checks++; if (bus.stall !== 6'b000000) begin failures++; $display("FAIL flush_beats_wait got=%b exp=000000", bus.stall); end
    @(negedge clk);
    idle();
    bus.stall_req = 6'b000100;
    #1;
    checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL flush_pulse got=%b exp=1", bus.flush); end
    checks++; if (bus.new_pc !== 16'h1234) begin failures++; $display("FAIL flush_pc got=%h exp=1234", bus.new_pc); end
    checks++; if (bus.stall !== 6'b000000) begin failures++; $display("FAIL flush_stall got=%b exp=000000", bus.stall); end
    @(negedge clk);
    bus.stall_req = 6'b000000;
    #1;
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL flush_end got=%b exp=0", bus.flush); end
    checks++; if (bus.new_pc !== 16'h1234) begin failures++; $display("FAIL flush_hold got=%h exp=1234", bus.new_pc); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.flush_req    = 1'b1;
    bus.flush_target = 16'h00AA;
    @(negedge clk);
    bus.flush_target = 16'h5555;
    #1;
    checks++; if (bus.new_pc !== 16'h00AA || bus.flush !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/00aa", bus.flush, bus.new_pc); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.new_pc !== 16'h5555 || bus.flush !== 1'b1) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/5555", bus.flush, bus.new_pc); end
    @(negedge clk);
    #1;
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", bus.flush); end
  endtask

  task automatic test_flush_in_wait();
    @(negedge clk);
    bus.wait_start = 1'b1;
    bus.wait_len   = 4'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.stall !== 6'b001111) begin failures++; $display("FAIL fw_stall[%0d] got=%b exp=001111", i, bus.stall); end
      checks++; if (bus.flush !== 1'b0 || bus.new_pc !== 16'h5555) begin failures++; $display("FAIL fw_noflush[%0d] got=%b/%h exp=0/5555", i, bus.flush, bus.new_pc); end
      @(negedge clk);
      idle();
      bus.flush_req    = (i < 2);
      bus.flush_target = (i == 0) ? 16'h0040 : 16'h0080;
    end
    #1;
    checks++; if (bus.flush !== 1'b1 || bus.new_pc !== 16'h0080) begin failures++; $display("FAIL fw_flush got=%b/%h exp=1/0080", bus.flush, bus.new_pc); end
    checks++; if (bus.stall !== 6'b000000) begin failures++; $display("FAIL fw_flush_stall got=%b exp=000000", bus.stall); end
    @(negedge clk);
    #1;
    checks++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL fw_end got=%b/%b exp=0/0", bus.flush, bus.busy); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    bus.clr_cnt   = 1'b0;
    bus.stall_req = 6'b000001;
    #1;
    checks++; if (bus.stall_cycles !== 16'h0000) begin failures++; $display("FAIL sat_clr got=%h exp=0000", bus.stall_cycles); end
    repeat (65534) @(negedge clk);
    #1;
    checks++; if (bus.stall_cycles !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", bus.stall_cycles); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", bus.stall_cycles); end
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    bus.clr_cnt = 1'b0;
    #1;
    checks++; if (bus.stall_cycles !== 16'h0000) begin failures++; $display("FAIL sat_clr_beats got=%h exp=0000", bus.stall_cycles); end
    idle();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    bus.wait_start = 1'b1;
    bus.wait_len   = 4'd8;
    @(negedge clk);
    idle();
    bus.flush_req    = 1'b1;
    bus.flush_target = 16'h0777;
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.stall !== 6'b001111) begin failures++; $display("FAIL rw_pre got=%b/%b exp=1/001111", bus.busy, bus.stall); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.stall !== 6'b000000) begin failures++; $display("FAIL rw_stall got=%b exp=000000", bus.stall); end
    checks++; if (bus.busy !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL rw_busy_flush got=%b/%b exp=0/0", bus.busy, bus.flush); end
    checks++; if (bus.stall_cycles !== 16'h0000 || bus.new_pc !== 16'h0000) begin failures++; $display("FAIL rw_cnt_pc got=%h/%h exp=0000/0000", bus.stall_cycles, bus.new_pc); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.stall !== 6'b000000 || bus.flush !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rw_after[%0d] got=%b/%b/%b exp=000000/0/0", i, bus.stall, bus.flush, bus.busy); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stall_map();
    test_wait();
    test_flush();
    test_back_to_back();
    test_flush_in_wait();
    test_saturate();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 6, number of pipeline stages (bit 0 = PC, bit NSTAGE-1 = WB).
REQ-002 SHALL have parameter MEM_STAGE, default 3, stage index frozen through by a memory wait; range 0..NSTAGE-1.
REQ-003 SHALL have parameter WAIT_W, default 4, width of the memory-wait length.
REQ-004 SHALL have parameter PC_W, default 16, width of the flush target address.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 stall_req  input  NSTAGE  per-stage stall request, bit k from stage k.
REQ-008 wait_start  input  1  start a multi-cycle memory wait.
REQ-009 wait_len  input  WAIT_W  memory wait length in cycles, sampled with wait_start.
REQ-010 flush_req  input  1  exception/branch flush request.
REQ-011 flush_target  input  PC_W  redirect address, sampled with flush_req.
REQ-012 clr_cnt  input  1  synchronous clear of the stall counter.
REQ-013 stall  output  NSTAGE  per-stage freeze vector.
REQ-014 flush  output  1  one-cycle pipeline flush pulse.
REQ-015 new_pc  output  PC_W  redirect address, valid while flush=1.
REQ-016 busy  output  1  high in WAIT or FLUSH state.
REQ-017 stall_cycles  output  16  saturating count of stalled cycles.

Function
REQ-018 SHALL implement states RUN, WAIT, FLUSH; RUN after reset.
REQ-019 SHALL form the effective request vector eff = stall_req, with bit MEM_STAGE forced to 1 when a wait is active (RUN with wait_start and wait_len!=0 accepted, or state WAIT).
REQ-020 SHALL drive stall combinationally as bits [h:0]=1 and the rest 0, where h is the highest set bit of eff; stall = all-zero when eff = 0.
REQ-021 SHALL drive stall all-zero in state FLUSH regardless of inputs.
REQ-022 In RUN, wait_start with wait_len=L>=2 SHALL load counter with L-1 and enter WAIT; L=1 stalls that cycle only and stays RUN; L=0 is ignored.
REQ-023 In WAIT, the counter SHALL decrement each cycle; when the counter equals 1, next state SHALL be RUN (or FLUSH if a flush is pending); total memory stall = L cycles including the start cycle.
REQ-024 wait_start in WAIT or FLUSH SHALL be ignored.
REQ-025 flush_req in RUN SHALL latch flush_target and enter FLUSH next cycle; flush_req beats wait_start in the same RUN cycle (wait dropped, no stall from it).
REQ-026 flush_req in WAIT SHALL set a pending flag and latch the target; a later flush_req in WAIT overwrites the target; the flush is issued in the cycle after WAIT ends.
REQ-027 In FLUSH, flush SHALL be 1 and new_pc SHALL equal the latched target for exactly that cycle; next state RUN, or FLUSH again if flush_req is asserted in the FLUSH cycle (new target latched).
REQ-028 flush and new_pc SHALL be registered (state-derived); new_pc SHALL hold its last value when flush=0.
REQ-029 stall_cycles SHALL increment on each cycle with stall!=0, saturate at 16'hFFFF; clr_cnt SHALL zero it, with clr_cnt beating increment.

Reset
REQ-030 rst=0 SHALL immediately force state RUN, counter 0, pending 0, flush 0, new_pc 0, busy 0, stall_cycles 0, stall 0.
REQ-031 Reset during WAIT or with a flush pending SHALL discard both; no flush pulse after release.

Verification
REQ-032 stall_req=6'b000100 in RUN -> stall=6'b000111 same cycle; stall_req=6'b010100 -> stall=6'b011111.
REQ-033 wait_start, wait_len=3, no stall_req -> stall=6'b001111 for exactly 3 cycles, busy high for 2 of them, then stall=0.
REQ-034 flush_req, flush_target=16'h1234 in RUN -> next cycle flush=1, new_pc=16'h1234, stall=0; following cycle flush=0.
REQ-035 wait_len=4 started, flush_req (16'h0040) in wait cycle 1, flush_req (16'h0080) in cycle 2 -> 4 stalled cycles, then one flush with new_pc=16'h0080.
REQ-036 stall_cycles preloaded to 16'hFFFE, 3 stalled cycles -> holds 16'hFFFF; clr_cnt with stall active -> 0.
REQ-037 rst driven low mid-WAIT (asynchronously, between edges) -> stall, flush, busy, stall_cycles 0 immediately; after release with idle inputs stall stays 0.
